// File: rtl/rtc_bus_ctrl.sv
// Bus-cycle generator for the external RTC's multiplexed address/data bus.
// Each accepted start runs an address phase and then a data phase, each made of
// setup, strobe and hold sub-phases. A final gap follows before returning to idle.
module rtc_bus_ctrl #(
  parameter int unsigned T_SU  = 2,
  parameter int unsigned T_PW  = 10,
  parameter int unsigned T_H   = 2,
  parameter int unsigned T_GAP = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic       i_rd_wr,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_wdata,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_rdata,
  output logic       o_rtc_cs_n,
  output logic       o_rtc_rd_n,
  output logic       o_rtc_wr_n,
  output logic       o_rtc_ad_n,
  output logic [7:0] o_ad_out,
  output logic       o_ad_oe,
  input  logic [7:0] i_ad_in
);

  // Zero lengths are illegal; treat them as one cycle.
  localparam int unsigned LenSu  = (T_SU  == 0) ? 1 : T_SU;
  localparam int unsigned LenPw  = (T_PW  == 0) ? 1 : T_PW;
  localparam int unsigned LenH   = (T_H   == 0) ? 1 : T_H;
  localparam int unsigned LenGap = (T_GAP == 0) ? 1 : T_GAP;
  localparam logic [7:0] LastSu  = 8'(LenSu - 1);
  localparam logic [7:0] LastPw  = 8'(LenPw - 1);
  localparam logic [7:0] LastH   = 8'(LenH - 1);
  localparam logic [7:0] LastGap = 8'(LenGap - 1);

  typedef enum logic [2:0] {
    StIdle, StASu, StAPw, StAH, StDSu, StDPw, StDH, StGap
  } state_e;

  state_e     r_state;
  logic [7:0] r_cnt;
  logic       r_rd_wr;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_rdata;
  logic       r_busy, r_done;
  logic       r_cs_n, r_rd_n, r_wr_n, r_ad_n, r_ad_oe;
  logic [7:0] r_ad_out;

  state_e     w_next;
  logic [7:0] w_last;
  logic       w_phase_end;
  logic       w_rw;
  logic [7:0] w_addr;
  logic [7:0] w_wdata;

  // Request operands: taken straight from the inputs on the accepting edge.
  assign w_rw    = (r_state == StIdle) ? i_rd_wr : r_rd_wr;
  assign w_addr  = (r_state == StIdle) ? i_addr  : r_addr;
  assign w_wdata = (r_state == StIdle) ? i_wdata : r_wdata;

  // Phase length lookup and next-state selection.
  always_comb begin
    w_last = 8'h00;
    unique case (r_state)
      StASu, StDSu: w_last = LastSu;
      StAPw, StDPw: w_last = LastPw;
      StAH,  StDH:  w_last = LastH;
      StGap:        w_last = LastGap;
      default:      w_last = 8'h00;
    endcase
    w_phase_end = (r_cnt == w_last);
    w_next = r_state;
    unique case (r_state)
      StIdle: if (i_start)     w_next = StASu;
      StASu:  if (w_phase_end) w_next = StAPw;
      StAPw:  if (w_phase_end) w_next = StAH;
      StAH:   if (w_phase_end) w_next = StDSu;
      StDSu:  if (w_phase_end) w_next = StDPw;
      StDPw:  if (w_phase_end) w_next = StDH;
      StDH:   if (w_phase_end) w_next = StGap;
      StGap:  if (w_phase_end) w_next = StIdle;
      default:                 w_next = StIdle;
    endcase
  end

  // State, phase counter and bus outputs, all registered against the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_cnt    <= 8'h00;
      r_rd_wr  <= 1'b0;
      r_addr   <= 8'h00;
      r_wdata  <= 8'h00;
      r_rdata  <= 8'h00;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cs_n   <= 1'b1;
      r_rd_n   <= 1'b1;
      r_wr_n   <= 1'b1;
      r_ad_n   <= 1'b1;
      r_ad_oe  <= 1'b0;
      r_ad_out <= 8'h00;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state || r_state == StIdle) ? 8'h00 : r_cnt + 8'h01;
      if (r_state == StIdle && i_start) begin
        r_rd_wr <= i_rd_wr;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end
      // Read data is sampled on the edge that ends the data strobe.
      if (r_state == StDPw && w_phase_end && !r_rd_wr) r_rdata <= i_ad_in;
      r_done   <= (r_state == StGap) && w_phase_end;
      r_busy   <= (w_next != StIdle);
      r_cs_n   <= 1'b1;
      r_rd_n   <= 1'b1;
      r_wr_n   <= 1'b1;
      r_ad_n   <= 1'b1;
      r_ad_oe  <= 1'b0;
      r_ad_out <= 8'h00;
      case (w_next)
        StASu, StAPw, StAH: begin
          // Address is always latched by the chip on a WR strobe.
          r_cs_n   <= (w_next == StAH);
          r_wr_n   <= (w_next != StAPw);
          r_ad_n   <= 1'b0;
          r_ad_oe  <= 1'b1;
          r_ad_out <= w_addr;
        end
        StDSu, StDPw, StDH: begin
          r_cs_n <= (w_next == StDH);
          if (w_rw) begin
            r_ad_oe  <= 1'b1;
            r_ad_out <= w_wdata;
            r_wr_n   <= (w_next != StDPw);
          end else begin
            r_rd_n <= (w_next != StDPw);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_rdata    = r_rdata;
  assign o_rtc_cs_n = r_cs_n;
  assign o_rtc_rd_n = r_rd_n;
  assign o_rtc_wr_n = r_wr_n;
  assign o_rtc_ad_n = r_ad_n;
  assign o_ad_out   = r_ad_out;
  assign o_ad_oe    = r_ad_oe;

endmodule
